// File: rtl/preparation.sv
// rtl/preparation.sv - 3x3 window preparation: tapped pixel delay line feeding the median sorter.
module preparation #(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       done_i,
  input  logic [7:0] data_i,
  output logic [7:0] data0_o,
  output logic [7:0] data1_o,
  output logic [7:0] data2_o,
  output logic [7:0] data3_o,
  output logic [7:0] data4_o,
  output logic [7:0] data5_o,
  output logic [7:0] data6_o,
  output logic [7:0] data7_o,
  output logic [7:0] data8_o,
  output logic       done_o
);

  localparam int TAPS = 2 * DEPTH + 3;
  localparam int CW   = $clog2(TAPS + 1);
  localparam logic [CW-1:0] FULL = CW'(TAPS);

  logic [7:0]    p [0:TAPS-1];
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;

  assign cnt_inc = (cnt == FULL) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < TAPS; k++) p[k] <= 8'd0;
      cnt    <= '0;
      done_o <= 1'b0;
    end else if (done_i) begin
      p[0] <= data_i;
      for (int k = 1; k < TAPS; k++) p[k] <= p[k-1];
      cnt    <= cnt_inc;
      done_o <= (cnt_inc >= FULL);
    end else begin
      done_o <= 1'b0;
    end
  end

  // Taps come straight off the history flops; with small DEPTH the row taps overlap by design.
  assign data8_o = p[0];
  assign data7_o = p[1];
  assign data6_o = p[2];
  assign data5_o = p[DEPTH];
  assign data4_o = p[DEPTH+1];
  assign data3_o = p[DEPTH+2];
  assign data2_o = p[2*DEPTH];
  assign data1_o = p[2*DEPTH+1];
  assign data0_o = p[2*DEPTH+2];

endmodule

// File: tb/tb_preparation.sv
// tb/tb_preparation.sv - scoreboard bench for the preparation window stage (DEPTH=2).
module tb_preparation;

  localparam int D    = 2;
  localparam int TAPS = 2 * D + 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       done_i;
  logic [7:0] data_i;
  logic [7:0] data0_o, data1_o, data2_o, data3_o, data4_o;
  logic [7:0] data5_o, data6_o, data7_o, data8_o;
  logic       done_o;

  preparation #(.DEPTH(D)) dut (
    .clk(clk), .rst(rst), .done_i(done_i), .data_i(data_i),
    .data0_o(data0_o), .data1_o(data1_o), .data2_o(data2_o),
    .data3_o(data3_o), .data4_o(data4_o), .data5_o(data5_o),
    .data6_o(data6_o), .data7_o(data7_o), .data8_o(data8_o),
    .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] w [9];
    logic       dn;
  } exp_t;

  exp_t q [$];
  int   m [TAPS];
  int   mcnt;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [7:0] obs [9];
  assign obs[0] = data0_o; assign obs[1] = data1_o; assign obs[2] = data2_o;
  assign obs[3] = data3_o; assign obs[4] = data4_o; assign obs[5] = data5_o;
  assign obs[6] = data6_o; assign obs[7] = data7_o; assign obs[8] = data8_o;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model_window(input logic dn);
    exp_t e;
    e.w[8] = 8'(m[0]);       e.w[7] = 8'(m[1]);       e.w[6] = 8'(m[2]);
    e.w[5] = 8'(m[D]);       e.w[4] = 8'(m[D+1]);     e.w[3] = 8'(m[D+2]);
    e.w[2] = 8'(m[2*D]);     e.w[1] = 8'(m[2*D+1]);   e.w[0] = 8'(m[2*D+2]);
    e.dn   = dn;
    return e;
  endfunction

  // One clock: drive at the falling edge, predict, then compare at the next falling edge.
  task automatic step(input logic v, input logic [7:0] d);
    logic dn;
    exp_t e;
    done_i = v;
    data_i = d;
    dn = 1'b0;
    if (!rst) begin
      for (int k = 0; k < TAPS; k++) m[k] = 0;
      mcnt = 0;
    end else if (v) begin
      for (int k = TAPS - 1; k > 0; k--) m[k] = m[k-1];
      m[0] = d;
      if (mcnt < TAPS) mcnt++;
      dn = (mcnt >= TAPS);
    end
    q.push_back(model_window(dn));
    @(posedge clk);
    @(negedge clk);
    e = q.pop_front();
    for (int k = 0; k < 9; k++) check($sformatf("data%0d", k), obs[k], e.w[k]);
    check("done_o", done_o, e.dn);
  endtask

  task automatic check_fixed(input string tag, input int w0, input int w1, input int w2,
                             input int w3, input int w4, input int w5, input int w6,
                             input int w7, input int w8);
    int w [9];
    w = '{w0, w1, w2, w3, w4, w5, w6, w7, w8};
    for (int k = 0; k < 9; k++) check($sformatf("%s_data%0d", tag, k), obs[k], w[k]);
  endtask

  initial begin
    rst    = 1'b0;
    done_i = 1'b0;
    data_i = 8'd0;
    mcnt   = 0;
    for (int k = 0; k < TAPS; k++) m[k] = 0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) step(1'($urandom_range(0, 1)), 8'($urandom));
    check("reset_done", done_o, 1'b0);
    rst = 1'b1;

    for (int v = 0; v < 256; v++) begin
      step(1'b1, 8'(v));
      if (v == 5) check("fill6_done", done_o, 1'b0);
      if (v == 6) begin
        check("fill7_done", done_o, 1'b1);
        check_fixed("fill7", 0, 1, 2, 2, 3, 4, 4, 5, 6);
      end
      step(1'b0, 8'($urandom));
      if (v == 6) check("fill7_clear", done_o, 1'b0);
      if (v == 50) begin
        for (int i = 0; i < 5; i++) step(1'b0, 8'($urandom));
        check_fixed("idle", 44, 45, 46, 46, 47, 48, 48, 49, 50);
      end
      if (v == 255) check_fixed("v255", 249, 250, 251, 251, 252, 253, 253, 254, 255);
    end

    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'(100 + i));
      check("b2b_done", done_o, 1'b1);
    end
    check_fixed("b2b", 113, 114, 115, 115, 116, 117, 117, 118, 119);

    for (int v = 0; v <= 100; v++) begin
      step(1'b1, 8'(v));
      step(1'b0, 8'd0);
    end
    step(1'b1, 8'd77);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 9; k++) check($sformatf("async_clr%0d", k), obs[k], 8'd0);
    check("async_clr_done", done_o, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom));
    rst = 1'b1;

    for (int v = 0; v < 256; v++) begin
      step(1'b1, 8'(v));
      if (v == 5) check("refill6_done", done_o, 1'b0);
      if (v == 6) begin
        check("refill7_done", done_o, 1'b1);
        check_fixed("refill7", 0, 1, 2, 2, 3, 4, 4, 5, 6);
      end
      step(1'b0, 8'($urandom));
    end

    check("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/preparation.md
# preparation

Window-preparation stage for the median filter datapath. Consumes a raster-ordered 8-bit pixel stream one strobe-qualified sample at a time. Maintains a tapped delay line spanning two image rows plus three pixels, and presents the 3x3 neighbourhood of the newest pixel as nine parallel registered outputs. The downstream median sorter takes these outputs together with a one-cycle valid strobe.

## Interface
- DEPTH, default 2: image row width in pixels; row-to-row tap spacing of the delay line; legal range ≥ 2.
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- done_i  input  1  input strobe; data_i is accepted on any rising clk edge where done_i=1.
- data_i  input  8  incoming pixel (grayscale), raster order.
- data0_o..data2_o  output  8 each  top window row, left to right.
- data3_o..data5_o  output  8 each  middle window row, left to right.
- data6_o..data8_o  output  8 each  bottom window row, left to right; data8_o is the newest pixel.
- done_o  output  1  window-valid strobe, one cycle per accepted pixel once the window is filled.

## Operation
- Internal history p[k], k = 0 … 2·DEPTH+2. p[0] is the most recently accepted pixel.
- On accept (done_i=1 at clk edge):
  - the whole history shifts by one;
  - data_i becomes p[0];
  - the fill counter increments, saturating at 2·DEPTH+3.
- Window mapping after each accept (n = newest, D = DEPTH):
  - data8_o=p[0], data7_o=p[1], data6_o=p[2]
  - data5_o=p[D], data4_o=p[D+1], data3_o=p[D+2]
  - data2_o=p[2D], data1_o=p[2D+1], data0_o=p[2D+2]
- The block does no row-edge masking and no border padding. Windows whose taps straddle a row boundary are emitted as-is. Border handling belongs to downstream logic.
- With DEPTH < 3, row taps overlap; for example, with D=2, data6_o and data5_o both equal p[2]. This is legal and must be reproduced exactly.
- When done_i=0: history, counter and data outputs hold their values.
- Arithmetic: the counter is wide enough for 2·DEPTH+3 (clog2-sized) and never wraps.
- Data outputs are visible before the fill completes. Unfilled taps read 0 because of reset.

## Timing
- Reset (rst=0, asynchronous): all history registers, all data outputs, the counter and done_o go to 0 immediately and stay at 0 while rst=0.
- Latency: data outputs are registered and reflect the new window one edge after the accept, i.e. after the same edge that samples data_i.
- done_o is registered and set to 1 on the accepting edge iff the counter value after the increment is ≥ 2·DEPTH+3. It is cleared on the next edge unless another accept occurs.
- Back-to-back done_i=1 is supported: one pixel per cycle, with done_o held high continuously once the window is filled.
- Reset mid-stream discards all history. The fill restarts, and the first done_o after reset follows the (2·DEPTH+3)-th new accept.
- The first pixel after release of reset is accepted on the first edge where rst=1 and done_i=1.

## Test plan
- Reset: hold rst=0 while toggling done_i/data_i → all nine outputs = 0 and done_o = 0 throughout.
- Fill (DEPTH=2): reset, then feed 0,1,2,… with done_i high for one cycle and low for the next.
  - After the 6th accepted pixel (value 5): done_o remains 0.
  - After the 7th (value 6): done_o=1 for one cycle.
  - Outputs data0..8 = 0,1,2,2,3,4,4,5,6.
- Steady state: continue the stream to value 255.
  - Every accept yields a one-cycle done_o.
  - After value 255 is accepted: data8=255, data7=254, data6=253, data5=253, data4=252, data3=251, data2=251, data1=250, data0=249.
- Idle hold: insert 5 cycles with done_i=0 mid-stream → outputs unchanged, done_o=0.
- Back-to-back: done_i held at 1 for 20 cycles after the fill → done_o stays 1 and the window shifts by exactly one pixel per cycle.
- Reset mid-operation: assert rst=0 after value 100, release, then restream 0..255 → outputs clear immediately, and the first done_o again follows the 7th new pixel with window 0,1,2,2,3,4,4,5,6.
